config_sweep_ctrl: RTL and testbench
====================================

# config_sweep_ctrl

Run controller for the branch-prediction-capable MIPS core. It sweeps all four combinations of `forward_EN` and `bp_enable`. For each combination it holds the core in reset, releases it, and watches the fetch PC until a halt address or a cycle limit is reached. It then records the cycle count and branch-predictor counters for that configuration. It sits above the processor top level and drives the core's `rst`, `forward_EN` and `bp_enable` inputs.

## Interface
Parameters:
- `RST_CYCLES`, default 4: cycles `cpu_rst` is held high before each run (≥1).
- `MAX_CYCLES`, default 4096: run-cycle limit per configuration (≥1).
- `CNT_W`, default 32: width of the cycle counter and stored counts.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle pulse that begins a sweep; accepted only in IDLE or DONE.
- `halt_pc` in 32: fetch address that marks program end.
- `pc_if` in 32: core IF-stage PC.
- `bp_total`, `bp_correct`, `bp_wrong` in 32 each: core predictor counters.
- `cpu_rst` out 1: reset to the core.
- `forward_EN` out 1: forwarding enable to the core.
- `bp_enable` out 1: branch-prediction enable to the core.
- `busy` out 1: sweep in progress.
- `done` out 1: sweep complete; held until the next `start`.
- `rd_idx` in 2: result slot to read.
- `rd_cycles` out `CNT_W`: stored cycle count for slot `rd_idx`.
- `rd_bp_total`, `rd_bp_correct`, `rd_bp_wrong` out 32 each: stored predictor counters for slot `rd_idx`.
- `rd_timeout` out 1: slot `rd_idx` ended by cycle limit, not halt.

## Operation
- Slot index `idx` (2 bits) selects the configuration: `forward_EN = idx[1]`, `bp_enable = idx[0]`. Order: 00, 01, 10, 11.
- IDLE:
  - `cpu_rst=1`, `busy=0`, `done=0`.
  - `start` → clear all slots, set `idx=0`, go to CORE_RST.
- CORE_RST:
  - `cpu_rst=1`, `busy=1`; `forward_EN`/`bp_enable` already reflect `idx`.
  - After `RST_CYCLES` cycles → RUN, with the run counter loaded to 1.
- RUN:
  - `cpu_rst=0`.
  - Each cycle compare `pc_if` to `halt_pc` and the run counter to `MAX_CYCLES`.
  - On a match or at the limit:
    - store the run counter into `cycles[idx]`;
    - store `bp_total`/`bp_correct`/`bp_wrong` as sampled that same cycle;
    - set `timeout[idx] = !match`.
  - Next state: if `idx==3` → DONE; otherwise increment `idx` and go to CORE_RST.
  - Otherwise the run counter increments by 1.
- DONE:
  - `cpu_rst=1`, `busy=0`, `done=1`; results retained.
  - `start` → clear slots, restart at `idx=0`.
- `start` while `busy=1` is ignored.
- Readout is combinational from the slot registers through `rd_idx`; it is valid at any time. Slots not yet written read 0.
- The cycle counter is `CNT_W` bits and never wraps, because the `MAX_CYCLES` check bounds it. `MAX_CYCLES` must fit in `CNT_W`.

## Timing
- Reset values:
  - `cpu_rst=1`, `forward_EN=0`, `bp_enable=0`, `busy=0`, `done=0`;
  - all slots 0, `idx=0`, state IDLE.
- `rst` mid-sweep: same values on the next edge; partial results are discarded.
- `forward_EN`/`bp_enable` change only on the edge that enters CORE_RST, so they are stable for the whole CORE_RST+RUN of a slot.
- `start` at edge T → `busy=1` and `cpu_rst=1` from T+1. `cpu_rst` falls at T+1+`RST_CYCLES`.
- Stored cycle count N = number of RUN cycles including the exit cycle.
  - If `pc_if==halt_pc` in the first RUN cycle, N=1.
- Slot period = `RST_CYCLES` + N cycles. `done` rises on the edge after the slot-3 exit cycle.
- Halt match and limit in the same cycle: halt wins, `timeout=0`.
- Stored counters are written on the exit-cycle edge. `cpu_rst` is asserted on the same edge, so the core counters clear afterwards.

## Structure
- Add to `defines.v`:
  - state encodings (IDLE, CORE_RST, RUN, DONE);
  - `` `SWEEP_SLOTS `` (4);
  - `` `SWEEP_IDX_LEN `` (2).
- Sub-module `sweep_result_bank`: 4-entry register array with a write port (idx, cycles, three counters, timeout), synchronous clear, and a combinational read port.
- The FSM and counters live in `config_sweep_ctrl`.

## Test plan
- `RST_CYCLES=4`; stub PC reaches `halt_pc=0x40` after 20 RUN cycles in every slot → each slot `cycles=20`, `timeout=0`; `done` rises 96 cycles after `start`; `forward_EN`/`bp_enable` sequence is 00,01,10,11.
- Stub counters `bp_total=7`, `bp_correct=5`, `bp_wrong=2` in slot 3 only → readout at `rd_idx=3` is 7/5/2; slots 0-2 read the values driven during their exit cycles.
- `halt_pc` never reached, `MAX_CYCLES=16` → all slots `cycles=16`, `timeout=1`.
- `halt_pc=0` with PC 0 in the first RUN cycle → `cycles=1`. Halt and limit coincide at `MAX_CYCLES` → `timeout=0`.
- `start` pulsed during RUN of slot 1 → ignored, sweep unaffected. `start` in DONE → slots cleared, new sweep begins.
- `rst` asserted during CORE_RST of slot 2 → next cycle IDLE, `cpu_rst=1`, all outputs and slots 0; a subsequent `start` completes normally.

Source files
------------

// File: rtl/config_sweep_ctrl_pkg.sv
// Shared types for the configuration sweep controller: FSM states, slot indexing, predictor counters.
// Pure declarations; no logic, no latency.
package config_sweep_ctrl_pkg;

    localparam int SWEEP_SLOTS   = 4;
    localparam int SWEEP_IDX_LEN = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CORE_RST = 2'd1,
        ST_RUN      = 2'd2,
        ST_DONE     = 2'd3
    } sweep_state_t;

    typedef logic [SWEEP_IDX_LEN-1:0] slot_idx_t;

    typedef struct packed {
        logic [31:0] total;
        logic [31:0] correct;
        logic [31:0] wrong;
    } bp_cnt_t;

endpackage

// File: rtl/sweep_result_bank.sv
// Four-slot result store: one registered write port, synchronous clear, combinational read.
// Writes land on the next edge; reads have zero latency; no backpressure.
module sweep_result_bank
    import config_sweep_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  slot_idx_t        wr_idx,
    input  logic [CNT_W-1:0] wr_cycles,
    input  bp_cnt_t          wr_cnt,
    input  logic             wr_timeout,
    input  slot_idx_t        rd_idx,
    output logic [CNT_W-1:0] rd_cycles,
    output bp_cnt_t          rd_cnt,
    output logic             rd_timeout
);

    logic [CNT_W-1:0]       cycles_q [SWEEP_SLOTS];
    bp_cnt_t                cnt_q    [SWEEP_SLOTS];
    logic [SWEEP_SLOTS-1:0] timeout_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < SWEEP_SLOTS; i++) begin
                cycles_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            timeout_q <= '0;
        end else if (wr_en) begin
            cycles_q[wr_idx]  <= wr_cycles;
            cnt_q[wr_idx]     <= wr_cnt;
            timeout_q[wr_idx] <= wr_timeout;
        end
    end

    assign rd_cycles  = cycles_q[rd_idx];
    assign rd_cnt     = cnt_q[rd_idx];
    assign rd_timeout = timeout_q[rd_idx];

endmodule

// File: rtl/config_sweep_ctrl.sv
// Runs the core once per (forward_EN, bp_enable) combination, logging cycles and predictor counters.
// Per slot: RST_CYCLES of core reset then up to MAX_CYCLES of run; start is ignored while busy.
module config_sweep_ctrl
    import config_sweep_ctrl_pkg::*;
#(
    parameter int RST_CYCLES = 4,
    parameter int MAX_CYCLES = 4096,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      halt_pc,
    input  logic [31:0]      pc_if,
    input  logic [31:0]      bp_total,
    input  logic [31:0]      bp_correct,
    input  logic [31:0]      bp_wrong,
    output logic             cpu_rst,
    output logic             forward_EN,
    output logic             bp_enable,
    output logic             busy,
    output logic             done,
    input  logic [1:0]       rd_idx,
    output logic [CNT_W-1:0] rd_cycles,
    output logic [31:0]      rd_bp_total,
    output logic [31:0]      rd_bp_correct,
    output logic [31:0]      rd_bp_wrong,
    output logic             rd_timeout
);

    localparam int               RC_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0]  RC_LAST   = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(MAX_CYCLES);
    localparam slot_idx_t        LAST_SLOT = SWEEP_IDX_LEN'(SWEEP_SLOTS - 1);

    sweep_state_t     state;
    slot_idx_t        idx;
    slot_idx_t        next_idx;
    logic [RC_W-1:0]  rst_cnt;
    logic [CNT_W-1:0] run_cnt;

    logic    halt_hit;
    logic    limit_hit;
    logic    run_exit;
    logic    sweep_go;
    bp_cnt_t cur_cnt;
    bp_cnt_t rd_cnt;

    assign halt_hit  = (pc_if == halt_pc);
    assign limit_hit = (run_cnt == RUN_LIMIT);
    assign run_exit  = (state == ST_RUN) && (halt_hit || limit_hit);
    assign sweep_go  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign next_idx  = idx + 1'b1;
    assign cur_cnt   = '{total: bp_total, correct: bp_correct, wrong: bp_wrong};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            rst_cnt    <= '0;
            run_cnt    <= '0;
            cpu_rst    <= 1'b1;
            forward_EN <= 1'b0;
            bp_enable  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_CORE_RST;
                        idx        <= '0;
                        rst_cnt    <= '0;
                        forward_EN <= 1'b0;
                        bp_enable  <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                ST_CORE_RST: begin
                    if (rst_cnt == RC_LAST) begin
                        state   <= ST_RUN;
                        run_cnt <= CNT_W'(1);
                        cpu_rst <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (run_exit) begin
                        // Core goes back into reset on the same edge its counters are captured.
                        cpu_rst <= 1'b1;
                        if (idx == LAST_SLOT) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state      <= ST_CORE_RST;
                            idx        <= next_idx;
                            rst_cnt    <= '0;
                            forward_EN <= next_idx[1];
                            bp_enable  <= next_idx[0];
                        end
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Halt takes priority over the limit, so a coincident hit is not a timeout.
    sweep_result_bank #(.CNT_W(CNT_W)) u_bank (
        .clk        (clk),
        .rst        (rst),
        .clr        (sweep_go),
        .wr_en      (run_exit),
        .wr_idx     (idx),
        .wr_cycles  (run_cnt),
        .wr_cnt     (cur_cnt),
        .wr_timeout (!halt_hit),
        .rd_idx     (rd_idx),
        .rd_cycles  (rd_cycles),
        .rd_cnt     (rd_cnt),
        .rd_timeout (rd_timeout)
    );

    assign rd_bp_total   = rd_cnt.total;
    assign rd_bp_correct = rd_cnt.correct;
    assign rd_bp_wrong   = rd_cnt.wrong;

endmodule

// File: tb/tb_config_sweep_ctrl.sv
// Randomized sweeps against a per-slot outcome model; a monitor pops expected slot results on each run exit.
module tb_config_sweep_ctrl;

    localparam int RSTC = 4;
    localparam int MAXC = 24;
    localparam int CW   = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   halt_pc = 32'h40;
    logic [31:0]   pc_if = '0;
    logic [31:0]   bp_total = '0, bp_correct = '0, bp_wrong = '0;
    logic          cpu_rst, forward_EN, bp_enable, busy, done;
    logic [1:0]    rd_idx = '0;
    logic [CW-1:0] rd_cycles;
    logic [31:0]   rd_bp_total, rd_bp_correct, rd_bp_wrong;
    logic          rd_timeout;

    always #5 clk = ~clk;

    config_sweep_ctrl #(.RST_CYCLES(RSTC), .MAX_CYCLES(MAXC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .halt_pc(halt_pc), .pc_if(pc_if),
        .bp_total(bp_total), .bp_correct(bp_correct), .bp_wrong(bp_wrong),
        .cpu_rst(cpu_rst), .forward_EN(forward_EN), .bp_enable(bp_enable),
        .busy(busy), .done(done), .rd_idx(rd_idx), .rd_cycles(rd_cycles),
        .rd_bp_total(rd_bp_total), .rd_bp_correct(rd_bp_correct),
        .rd_bp_wrong(rd_bp_wrong), .rd_timeout(rd_timeout)
    );

    // Per-slot stub program: halt after h RUN cycles (0 = never); counters = seed + inc*k.
    int          h_cfg  [4];
    logic [31:0] seed_t [4];
    logic [31:0] seed_c [4];
    logic [31:0] seed_w [4];
    logic [31:0] inc    [4];

    typedef struct {
        int          slot;
        logic [31:0] cyc;
        logic [31:0] tot;
        logic [31:0] cor;
        logic [31:0] wro;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_rec[4];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Core stub: k counts RUN cycles since cpu_rst dropped.
    initial begin
        int k;
        int s;
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            if (cpu_rst) k = 0;
            else k++;
            s = {30'd0, forward_EN, bp_enable};
            if (!cpu_rst && h_cfg[s] != 0 && k >= h_cfg[s]) pc_if = halt_pc;
            else pc_if = halt_pc + 32'h4;
            bp_total   = seed_t[s] + inc[s] * 32'(k);
            bp_correct = seed_c[s] + inc[s] * 32'(k);
            bp_wrong   = seed_w[s] + inc[s] * 32'(k);
        end
    end

    // Monitor: a 0->1 edge on cpu_rst marks a slot exit; the slot is the config held during that run.
    initial begin
        logic       crst_prev;
        logic [1:0] sl_prev;
        exp_t       e;
        crst_prev = 1'b1;
        sl_prev   = 2'd0;
        forever begin
            @(negedge clk);
            if (!crst_prev && cpu_rst && !rst) begin
                rd_idx = sl_prev;
                #1;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_exit: slot %0d finished with nothing queued", sl_prev);
                end else begin
                    e = exp_q.pop_front();
                    chk("exit_slot",    64'(sl_prev),       64'(e.slot));
                    chk("exit_cycles",  64'(rd_cycles),     64'(e.cyc));
                    chk("exit_total",   64'(rd_bp_total),   64'(e.tot));
                    chk("exit_correct", 64'(rd_bp_correct), 64'(e.cor));
                    chk("exit_wrong",   64'(rd_bp_wrong),   64'(e.wro));
                    chk("exit_timeout", 64'(rd_timeout),    64'(e.to));
                end
            end
            crst_prev = cpu_rst;
            sl_prev   = {forward_EN, bp_enable};
        end
    end

    task automatic check_slots_zero();
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            #1;
            chk("clr_cycles",  64'(rd_cycles),     64'd0);
            chk("clr_total",   64'(rd_bp_total),   64'd0);
            chk("clr_correct", 64'(rd_bp_correct), 64'd0);
            chk("clr_wrong",   64'(rd_bp_wrong),   64'd0);
            chk("clr_timeout", 64'(rd_timeout),    64'd0);
        end
    endtask

    task automatic check_reset_state();
        chk("rst_cpu_rst", 64'(cpu_rst),    64'd1);
        chk("rst_fwd",     64'(forward_EN), 64'd0);
        chk("rst_bp",      64'(bp_enable),  64'd0);
        chk("rst_busy",    64'(busy),       64'd0);
        chk("rst_done",    64'(done),       64'd0);
        check_slots_zero();
    endtask

    task automatic readback_model();
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            #1;
            chk("rb_cycles",  64'(rd_cycles),     64'(exp_rec[i].cyc));
            chk("rb_total",   64'(rd_bp_total),   64'(exp_rec[i].tot));
            chk("rb_correct", 64'(rd_bp_correct), 64'(exp_rec[i].cor));
            chk("rb_wrong",   64'(rd_bp_wrong),   64'(exp_rec[i].wro));
            chk("rb_timeout", 64'(rd_timeout),    64'(exp_rec[i].to));
        end
    endtask

    task automatic randomize_cfg();
        halt_pc = $urandom & 32'hFFFF_FFFC;
        for (int s = 0; s < 4; s++) begin
            h_cfg[s]  = int'($urandom_range(0, MAXC + 6));
            seed_t[s] = $urandom;
            seed_c[s] = $urandom;
            seed_w[s] = $urandom;
            inc[s]    = 32'($urandom_range(0, 3));
        end
    endtask

    task automatic run_sweep(input bit inj_start, input bit inj_rst);
        int total;
        int cnt;
        int n;
        bit seen;
        bit injected;
        total = 0;
        cnt = 0;
        seen = 1'b0;
        injected = 1'b0;
        for (int s = 0; s < 4; s++) begin
            n = (h_cfg[s] == 0 || h_cfg[s] > MAXC) ? MAXC : h_cfg[s];
            exp_rec[s].slot = s;
            exp_rec[s].cyc  = 32'(n);
            exp_rec[s].tot  = seed_t[s] + inc[s] * 32'(n);
            exp_rec[s].cor  = seed_c[s] + inc[s] * 32'(n);
            exp_rec[s].wro  = seed_w[s] + inc[s] * 32'(n);
            exp_rec[s].to   = (h_cfg[s] == 0 || h_cfg[s] > MAXC);
            exp_q.push_back(exp_rec[s]);
            total += RSTC + n;
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("go_busy",    64'(busy),       64'd1);
        chk("go_cpu_rst", 64'(cpu_rst),    64'd1);
        chk("go_done",    64'(done),       64'd0);
        chk("go_cfg",     64'({forward_EN, bp_enable}), 64'd0);
        check_slots_zero();
        while (!seen && cnt < total + 200) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            start = 1'b0;
            if (inj_rst && busy && cpu_rst && forward_EN && !bp_enable) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_reset_state();
                exp_q.delete();
                return;
            end
            if (inj_start && !injected && !cpu_rst && !forward_EN && bp_enable) begin
                start = 1'b1;
                injected = 1'b1;
            end
            if (done) seen = 1'b1;
        end
        chk("done_seen",    64'(seen), 64'd1);
        chk("done_latency", 64'(cnt),  64'(total));
        @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("done_held",     64'(done),          64'd1);
        chk("done_busy",     64'(busy),          64'd0);
        chk("done_cpu_rst",  64'(cpu_rst),       64'd1);
        readback_model();
    endtask

    initial begin
        for (int s = 0; s < 4; s++) begin
            h_cfg[s] = 20;
            seed_t[s] = $urandom;
            seed_c[s] = $urandom;
            seed_w[s] = $urandom;
            inc[s] = 32'd1;
        end
        seed_t[3] = 32'd7;
        seed_c[3] = 32'd5;
        seed_w[3] = 32'd2;
        inc[3] = 32'd0;
        repeat (3) @(negedge clk);
        check_reset_state();
        rst = 1'b0;

        // Every slot halts at 0x40 after 20 cycles: done lands 96 cycles after start.
        run_sweep(1'b0, 1'b0);

        // Never halts: every slot stops at the limit and flags timeout.
        for (int s = 0; s < 4; s++) h_cfg[s] = 0;
        run_sweep(1'b0, 1'b0);

        // Halt at PC 0 on the first cycle, halt coinciding with the limit, halt just past it.
        halt_pc = 32'h0;
        h_cfg[0] = 1;
        h_cfg[1] = MAXC;
        h_cfg[2] = MAXC + 1;
        h_cfg[3] = 0;
        run_sweep(1'b1, 1'b0);

        randomize_cfg();
        run_sweep(1'b0, 1'b1);

        for (int r = 0; r < 4; r++) begin
            randomize_cfg();
            run_sweep((r % 2) == 1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_chk, n_fail);
        $fatal(1);
    end

endmodule
